// File: rtl/lab_pkg.sv
// Shared definitions for the lab counter/monitor blocks.
//   mon_state_e : monitor FSM state (2 bits)
//   CNT_W       : default width of the monitored count
//   WRAP_W      : default width of the wrap counter
//   ERR_W       : default width of the saturating error counter
package lab_pkg;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WRAP_W = 8;
  localparam int unsigned ERR_W  = 4;

  typedef enum logic [1:0] {
    StAcq    = 2'd0,
    StTrack  = 2'd1,
    StLocked = 2'd2,
    StFault  = 2'd3
  } mon_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk_i   : clock
//   rst_ni  : asynchronous reset, active low (count -> 0)
//   clr_i   : synchronous clear, wins over inc_i
//   inc_i   : increment request; ignored once the count is all-ones
//   count_o : current count
module sat_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/count_sequence_monitor.sv
// Monitors a free-running modulo-2^WIDTH up-counter.
// Checks that each sample is the previous sample plus one, locks after LOCK_CYCLES
// consecutive good steps and latches a sticky fault on a broken step while locked.
//   clk, rst_n   : clock and asynchronous active-low reset
//   count_in     : counter value under test
//   clear        : synchronous clear, active high, overrides every transition
//   match_val    : value that fires match_pulse
//   match_pulse  : one-cycle pulse, previous sample equalled match_val
//   wrap_pulse   : one-cycle pulse, legal all-ones -> 0 step seen
//   wrap_count   : number of legal wraps (modulo 2^WRAP_W)
//   locked       : monitor is in LOCKED
//   fault        : monitor is in FAULT (sticky until clear/reset)
//   err_count    : bad steps seen in LOCKED/FAULT, saturating
module count_sequence_monitor
  import lab_pkg::*;
#(
  parameter int unsigned WIDTH       = CNT_W,
  parameter int unsigned WRAP_W      = lab_pkg::WRAP_W,
  parameter int unsigned ERR_W       = lab_pkg::ERR_W,
  parameter int unsigned LOCK_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              clear,
  input  logic [WIDTH-1:0]  match_val,
  output logic              match_pulse,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              locked,
  output logic              fault,
  output logic [ERR_W-1:0]  err_count
);

  localparam int unsigned StreakW = 4;

  mon_state_e          state_q, state_d;
  logic [WIDTH-1:0]    prev_q;
  logic [WRAP_W-1:0]   wrap_cnt_q, wrap_cnt_d;
  logic                match_q, wrap_q;
  logic [StreakW-1:0]  streak;
  logic                streak_clr, streak_inc;
  logic                err_inc;
  logic                good;
  logic                is_wrap;
  logic                lock_hit;

  // Width-truncated increment, so all-ones -> 0 counts as good.
  assign good     = (count_in == prev_q + WIDTH'(1));
  // A wrap step is by construction a good step, so a bad step never wraps.
  assign is_wrap  = (state_q != StAcq) && (prev_q == '1) && (count_in == '0);
  // This good step completes the required streak.
  assign lock_hit = (({1'b0, streak} + 5'd1) == 5'(LOCK_CYCLES));

  always_comb begin
    state_d    = state_q;
    streak_clr = 1'b0;
    streak_inc = 1'b0;
    err_inc    = 1'b0;
    if (clear) begin
      state_d    = StAcq;
      streak_clr = 1'b1;
    end else begin
      unique case (state_q)
        StAcq: begin
          // prev is not yet meaningful; just start tracking.
          state_d    = StTrack;
          streak_clr = 1'b1;
        end
        StTrack: begin
          if (good) begin
            streak_inc = 1'b1;
            if (lock_hit) state_d = StLocked;
          end else begin
            streak_clr = 1'b1;
          end
        end
        StLocked: begin
          if (!good) begin
            state_d = StFault;
            err_inc = 1'b1;
          end
        end
        StFault: begin
          if (!good) err_inc = 1'b1;
        end
        default: state_d = StAcq;
      endcase
    end
  end

  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (clear) begin
      wrap_cnt_d = '0;
    end else if (is_wrap) begin
      wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StAcq;
      prev_q     <= '0;
      wrap_cnt_q <= '0;
      match_q    <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= count_in;
      wrap_cnt_q <= wrap_cnt_d;
      match_q    <= !clear && (count_in == match_val);
      wrap_q     <= !clear && is_wrap;
    end
  end

  sat_counter #(
    .Width (StreakW)
  ) u_streak (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (streak_clr),
    .inc_i   (streak_inc),
    .count_o (streak)
  );

  sat_counter #(
    .Width (ERR_W)
  ) u_err (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (clear),
    .inc_i   (err_inc),
    .count_o (err_count)
  );

  assign match_pulse = match_q;
  assign wrap_pulse  = wrap_q;
  assign wrap_count  = wrap_cnt_q;
  assign locked      = (state_q == StLocked);
  assign fault       = (state_q == StFault);

endmodule

// File: tb/tb_count_sequence_monitor.sv
module tb_count_sequence_monitor;

  localparam int LC = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] count_in = '0;
  logic [3:0] match_val = '0;
  logic       match_pulse, wrap_pulse, locked, fault;
  logic [7:0] wrap_count;
  logic [3:0] err_count;

  int errors = 0;
  int checks = 0;

  count_sequence_monitor #(
    .WIDTH       (4),
    .WRAP_W      (8),
    .ERR_W       (4),
    .LOCK_CYCLES (LC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .count_in    (count_in),
    .clear       (clear),
    .match_val   (match_val),
    .match_pulse (match_pulse),
    .wrap_pulse  (wrap_pulse),
    .wrap_count  (wrap_count),
    .locked      (locked),
    .fault       (fault),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  // Reference model: outputs expected after the most recent edge.
  bit m_acq;
  int m_prev, m_run, m_wraps, m_errs;
  bit m_locked, m_fault, m_match, m_wrap;

  task automatic model_reset();
    m_acq = 1; m_prev = 0; m_run = 0; m_wraps = 0; m_errs = 0;
    m_locked = 0; m_fault = 0; m_match = 0; m_wrap = 0;
  endtask

  task automatic model_step(input int s, input bit c, input int mv);
    bit g;
    m_match = !c && (s == mv);
    m_wrap  = 0;
    if (c) begin
      m_acq = 1; m_run = 0; m_locked = 0; m_fault = 0; m_wraps = 0; m_errs = 0;
    end else if (m_acq) begin
      m_acq = 0; m_run = 0;
    end else begin
      g = (s == (m_prev + 1) % 16);
      m_wrap = (m_prev == 15) && (s == 0);
      if (m_wrap) m_wraps = (m_wraps + 1) % 256;
      if (m_fault) begin
        if (!g) m_errs = (m_errs < 15) ? m_errs + 1 : 15;
      end else if (m_locked) begin
        if (!g) begin
          m_locked = 0; m_fault = 1;
          m_errs = (m_errs < 15) ? m_errs + 1 : 15;
        end
      end else if (g) begin
        m_run++;
        if (m_run >= LC) m_locked = 1;
      end else begin
        m_run = 0;
      end
    end
    m_prev = s;
  endtask

  task automatic drive(input int v, input bit c);
    count_in = 4'(v);
    clear    = c;
    @(posedge clk);
    model_step(v, c, int'(match_val));
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    checks++;
    if ({locked, fault, match_pulse, wrap_pulse} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000", {locked, fault, match_pulse, wrap_pulse});
    end
    checks++;
    if (wrap_count !== 8'd0 || err_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_counts: got wrap=%0d err=%0d want 0 0", wrap_count, err_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    for (int i = 0; i <= 4; i++) begin
      drive(i, 1'b0);
      checks++;
      if (locked !== (i >= 3)) begin
        errors++;
        $display("FAIL lock_seq[%0d]: got locked=%b want %b", i, locked, i >= 3);
      end
    end
    checks++;
    if (fault !== 1'b0 || err_count !== 4'd0 || locked !== m_locked) begin
      errors++;
      $display("FAIL lock_clean: got fault=%b err=%0d locked=%b want 0 0 %b",
               fault, err_count, locked, m_locked);
    end
  endtask

  task automatic test_wrap();
    for (int i = 5; i <= 17; i++) begin
      drive(i % 16, 1'b0);
      checks++;
      if (wrap_pulse !== (i == 16) || wrap_count !== ((i >= 16) ? 8'd1 : 8'd0)) begin
        errors++;
        $display("FAIL wrap[%0d]: got pulse=%b cnt=%0d want %b %0d", i % 16, wrap_pulse,
                 wrap_count, i == 16, (i >= 16) ? 1 : 0);
      end
      checks++;
      if (locked !== 1'b1) begin
        errors++;
        $display("FAIL wrap_locked[%0d]: got %b want 1", i % 16, locked);
      end
    end
  endtask

  task automatic test_fault();
    int seq [8] = '{2, 3, 4, 5, 6, 9, 10, 11};
    for (int i = 0; i < 8; i++) begin
      drive(seq[i], 1'b0);
      checks++;
      if (fault !== (i >= 5) || locked !== (i < 5) || err_count !== ((i >= 5) ? 4'd1 : 4'd0))
      begin
        errors++;
        $display("FAIL fault[%0d]: got fault=%b locked=%b err=%0d want %b %b %0d", seq[i],
                 fault, locked, err_count, i >= 5, i < 5, (i >= 5) ? 1 : 0);
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      drive(7, 1'b0);
      checks++;
      if (err_count !== 4'((i + 2 < 15) ? i + 2 : 15) || fault !== 1'b1 || wrap_pulse !== 1'b0)
      begin
        errors++;
        $display("FAIL saturate[%0d]: got err=%0d fault=%b wrap=%b want %0d 1 0", i, err_count,
                 fault, wrap_pulse, (i + 2 < 15) ? i + 2 : 15);
      end
    end
  endtask

  task automatic test_match_clear();
    match_val = 4'd0;
    drive(15, 1'b0);
    drive(0, 1'b1);
    checks++;
    if ({match_pulse, wrap_pulse, locked, fault} !== 4'b0 || wrap_count !== 8'd0 ||
        err_count !== 4'd0) begin
      errors++;
      $display("FAIL clear: got m=%b w=%b l=%b f=%b wc=%0d ec=%0d want all 0", match_pulse,
               wrap_pulse, locked, fault, wrap_count, err_count);
    end
    drive(0, 1'b0);
    checks++;
    if (match_pulse !== 1'b1 || wrap_pulse !== 1'b0) begin
      errors++;
      $display("FAIL match_after_clear: got m=%b w=%b want 1 0", match_pulse, wrap_pulse);
    end
    drive(1, 1'b0);
    checks++;
    if (match_pulse !== 1'b0) begin
      errors++;
      $display("FAIL match_once: got %b want 0", match_pulse);
    end
  endtask

  task automatic test_async_reset();
    // prev is 1 here; walk up through three wraps.
    for (int i = 2; i <= 16 * 3 + 1; i++) drive(i % 16, 1'b0);
    checks++;
    if (wrap_count !== 8'd3 || locked !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got wc=%0d locked=%b want 3 1", wrap_count, locked);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({locked, fault, match_pulse, wrap_pulse} !== 4'b0 || wrap_count !== 8'd0 ||
        err_count !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: got l=%b f=%b m=%b w=%b wc=%0d ec=%0d want all 0", locked,
               fault, match_pulse, wrap_pulse, wrap_count, err_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 5; i <= 8; i++) begin
      drive(i, 1'b0);
      checks++;
      if (locked !== (i == 8)) begin
        errors++;
        $display("FAIL relock[%0d]: got locked=%b want %b", i, locked, i == 8);
      end
    end
  endtask

  task automatic test_random();
    int r, v;
    bit c;
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 80)      v = (m_prev + 1) % 16;
      else if (r < 88) v = m_prev;
      else             v = int'($urandom_range(0, 15));
      c = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 19) == 0) match_val = 4'($urandom_range(0, 15));
      drive(v, c);
      checks++;
      if (locked !== m_locked || fault !== m_fault) begin
        errors++;
        $display("FAIL rand_state[%0d]: got l=%b f=%b want %b %b", i, locked, fault,
                 m_locked, m_fault);
      end
      checks++;
      if (match_pulse !== m_match || wrap_pulse !== m_wrap) begin
        errors++;
        $display("FAIL rand_pulse[%0d]: got m=%b w=%b want %b %b", i, match_pulse,
                 wrap_pulse, m_match, m_wrap);
      end
      checks++;
      if (wrap_count !== 8'(m_wraps) || err_count !== 4'(m_errs)) begin
        errors++;
        $display("FAIL rand_count[%0d]: got wc=%0d ec=%0d want %0d %0d", i, wrap_count,
                 err_count, m_wraps, m_errs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_fault();
    test_saturation();
    test_match_clear();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/count_sequence_monitor.md
Name: count_sequence_monitor

Overview:
- Downstream consumer of the 4-bit up-counter. Samples the counter's output on every clock.
- Checks that successive values form a legal modulo-16 increment sequence, declares lock after a good streak, and latches a sticky fault if the sequence breaks while locked.
- Also provides a programmable match pulse, a wrap (15->0) pulse and wrap/error counters for lab board LEDs and test points.

Parameters:
- WIDTH, 4, width of the monitored count.
- WRAP_W, 8, width of the wrap counter.
- ERR_W, 4, width of the saturating error counter.
- LOCK_CYCLES, 3, consecutive good increments needed to enter LOCKED; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock, same clock as the counter.
- rst_n  input  1  asynchronous reset, active low.
- count_in  input  WIDTH  counter value under test.
- clear  input  1  synchronous clear, active high.
- match_val  input  WIDTH  value that triggers match_pulse.
- match_pulse  output  1  one-cycle pulse: sampled count equalled match_val.
- wrap_pulse  output  1  one-cycle pulse: legal 15->0 step seen.
- wrap_count  output  WRAP_W  number of legal wraps, modulo 2^WRAP_W.
- locked  output  1  high in LOCKED state.
- fault  output  1  high in FAULT state (sticky).
- err_count  output  ERR_W  bad steps seen in LOCKED/FAULT; saturates at all-ones.

Behaviour:
- Reset (rst_n low, asynchronous): state=ACQ, prev=0, streak=0, all outputs 0.
- Every cycle: prev <= count_in.
- good = (count_in == prev+1 mod 2^WIDTH). Width-truncated add, so 15->0 is good. bad = not good. good/bad are evaluated only outside ACQ.
- All outputs are registered. Each reflects the sample taken at the previous rising edge (1-cycle latency).
- States:
  - ACQ: no valid prev. Next cycle -> TRACK, streak=0. No good/bad evaluation.
  - TRACK: on good, streak++. If streak+1 == LOCK_CYCLES -> LOCKED. On bad, streak=0 and stay in TRACK; err_count is not incremented.
  - LOCKED: locked=1. On good, stay. On bad -> FAULT, err_count++ (saturating).
  - FAULT: fault=1, locked=0. Every further bad step increments err_count (saturating). Leaves only via clear or reset; good steps do not recover.
- match_pulse: count_in == match_val in any state, including ACQ. Pulses once per matching sample.
- wrap_pulse: asserted when not in ACQ, prev==all-ones and count_in==0. wrap_count increments on the same edge and wraps 255->0 silently.
- clear has priority over all transitions in that cycle:
  - state -> ACQ, streak=0, wrap_count=0, err_count=0.
  - locked, fault, match_pulse and wrap_pulse are 0 the following cycle.
  - prev still loads count_in.
- Simultaneous events: wrap and match on the same sample assert both pulses. A bad step never produces wrap_pulse.
- A held count (count_in == prev) is bad.
- Reset mid-operation: immediate return to the reset values above. Tracking resumes through ACQ.
- err_count saturation: at all-ones, further bad steps leave it unchanged; fault stays 1.

Decomposition:
- Shared package lab_pkg:
  - monitor state enum {ACQ, TRACK, LOCKED, FAULT}, 2 bits.
  - default width constants CNT_W=4, WRAP_W=8, ERR_W=4.
- One sub-module: sat_counter. Parameterised width, synchronous clr and inc, holds at all-ones. Used for err_count; also usable for streak.
- FSM, prev register, comparators and wrap counter stay in count_sequence_monitor.

Test Plan:
- Lock acquisition: reset, then drive count_in 0,1,2,3,4. Required: locked=1 the cycle after the sample "3" (streak 3); fault=0; err_count=0.
- Wrap: while locked, drive 14,15,0,1. Required: wrap_pulse exactly one cycle, the cycle after sample 0; wrap_count 0->1; locked stays 1.
- Fault and sticky: while locked, drive 5,6,9,10,11. Required: fault=1 and locked=0 the cycle after sample 9; err_count=1; fault stays 1 through the good steps 10,11.
- Saturation: in FAULT, drive 20 held/illegal samples (e.g. constant 7). Required: err_count climbs to 15 and stays at 15; no wrap_pulse.
- Match plus clear: match_val=0, drive 15,0 with clear=1 on the sample-0 cycle. Required, next cycle: match_pulse=0, wrap_pulse=0, state ACQ, wrap_count=0, err_count=0. With clear=0, the next sample of 0 gives match_pulse=1.
- Async reset mid-stream: assert rst_n=0 between clock edges while locked with wrap_count=3. Required: locked, fault, pulses and counters read 0 immediately, before the next edge. After release, ACQ then TRACK; relock takes LOCK_CYCLES good steps.
